// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the instruction/data memory bus arbiter.
//   arbState_e : FSM state encodings (IDLE, GNT_I, GNT_D, RESP)
//   WE_READ    : byte-enable pattern that marks a read
//   GNT_SEL_*  : encoding of the grant-select bit produced by the pick logic
//   DCNT_W     : width of the data-grant starvation counter
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2,
    ARB_RESP  = 2'd3
  } arbState_e;

  localparam logic [3:0] WE_READ   = 4'b0000;
  localparam logic       GNT_SEL_I = 1'b0;
  localparam logic       GNT_SEL_D = 1'b1;
  localparam int         DCNT_W    = 4;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// mem_arb_pick
// Purely combinational grant policy, kept apart from the FSM so both
// policy builds share the same sequencing logic.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking,
// otherwise data-first with an instruction anti-starvation cap.
// Ports:
//   iReq, dReq : pending requests from the fetch and data ports
//   dCnt       : consecutive D grants made while I was waiting (default build)
//   lastGnt    : side granted most recently (round-robin build)
//   gntSel     : GNT_SEL_I or GNT_SEL_D; only meaningful when a request is pending
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
`ifndef ARB_ROUND_ROBIN_EN
#(
  parameter int STARVE_MAX = 4
)
`endif
(
  input  logic              iReq,
  input  logic              dReq,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic              lastGnt,
`else
  input  logic [DCNT_W-1:0] dCnt,
`endif
  output logic              gntSel
);

`ifndef ARB_ROUND_ROBIN_EN
  localparam logic [DCNT_W-1:0] STARVE_CAP = DCNT_W'(STARVE_MAX);
`endif

  // A lone requester always wins; only a tie consults the policy state.
  always_comb begin
    gntSel = GNT_SEL_D;
    if (iReq && !dReq) begin
      gntSel = GNT_SEL_I;
    end else if (iReq && dReq) begin
`ifdef ARB_ROUND_ROBIN_EN
      gntSel = (lastGnt == GNT_SEL_D) ? GNT_SEL_I : GNT_SEL_D;
`else
      gntSel = (dCnt == STARVE_CAP) ? GNT_SEL_I : GNT_SEL_D;
`endif
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-port memory bus between the fetch port (I) and the
// memory-stage data port (D). Each access is one req/ack handshake on the
// bus; stall is raised while either requester is still waiting.
// Build option: ARB_ROUND_ROBIN_EN (see mem_arb_pick).
// Ports:
//   clk, rst                  : clock (rising edge), async active-low reset
//   i_req/i_addr/i_rdata/i_ack: instruction fetch port
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_ack : data port, d_we==0 is a read
//   m_req/m_we/m_addr/m_wdata : registered bus request towards memory
//   m_rdata/m_ack             : memory response, m_ack honoured only in a grant
//   stall                     : combinational pipeline stall
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic [3:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic [3:0]    m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          stall
);

  arbState_e     state, stateNext;
  logic          mReqNext, iAckNext, dAckNext, gntSel;
  logic [3:0]    mWeNext;
  logic [AW-1:0] mAddrNext;
  logic [DW-1:0] mWdataNext, iRdataNext, dRdataNext;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGnt, lastGntNext;

  mem_arb_pick uPick (
    .iReq    (i_req),
    .dReq    (d_req),
    .lastGnt (lastGnt),
    .gntSel  (gntSel)
  );
`else
  localparam logic [DCNT_W-1:0] STARVE_CAP = DCNT_W'(STARVE_MAX);
  logic [DCNT_W-1:0] dCnt, dCntNext;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) uPick (
    .iReq   (i_req),
    .dReq   (d_req),
    .dCnt   (dCnt),
    .gntSel (gntSel)
  );
`endif

  // Ack outputs are registered, so stall drops in the requester's ack cycle.
  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  // State and all registered outputs; reset abandons any bus access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      m_req   <= 1'b0;
      m_we    <= WE_READ;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastGnt <= GNT_SEL_I;
`else
      dCnt    <= '0;
`endif
    end else begin
      state   <= stateNext;
      m_req   <= mReqNext;
      m_we    <= mWeNext;
      m_addr  <= mAddrNext;
      m_wdata <= mWdataNext;
      i_ack   <= iAckNext;
      d_ack   <= dAckNext;
      i_rdata <= iRdataNext;
      d_rdata <= dRdataNext;
`ifdef ARB_ROUND_ROBIN_EN
      lastGnt <= lastGntNext;
`else
      dCnt    <= dCntNext;
`endif
    end
  end

  // Next-state logic. Grants are only issued from IDLE; RESP exists because
  // the acked requester still shows req during its ack cycle and must not be
  // granted a second time.
  always_comb begin
    stateNext  = state;
    mReqNext   = m_req;
    mWeNext    = m_we;
    mAddrNext  = m_addr;
    mWdataNext = m_wdata;
    iAckNext   = 1'b0;
    dAckNext   = 1'b0;
    iRdataNext = i_rdata;
    dRdataNext = d_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    lastGntNext = lastGnt;
`else
    dCntNext    = dCnt;
`endif
    case (state)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          mReqNext = 1'b1;
          if (gntSel == GNT_SEL_D) begin
            mWeNext    = d_we;
            mAddrNext  = d_addr;
            mWdataNext = d_wdata;
            stateNext  = ARB_GNT_D;
`ifdef ARB_ROUND_ROBIN_EN
            lastGntNext = GNT_SEL_D;
`else
            // Count only D grants that overtook a waiting fetch; saturate.
            if (!i_req) begin
              dCntNext = '0;
            end else if (dCnt != STARVE_CAP) begin
              dCntNext = dCnt + 1'b1;
            end
`endif
          end else begin
            mWeNext   = WE_READ;
            mAddrNext = i_addr;
            stateNext = ARB_GNT_I;
`ifdef ARB_ROUND_ROBIN_EN
            lastGntNext = GNT_SEL_I;
`else
            dCntNext    = '0;
`endif
          end
        end
      end
      ARB_GNT_I: begin
        if (m_ack) begin
          mReqNext   = 1'b0;
          mWeNext    = WE_READ;
          iAckNext   = 1'b1;
          iRdataNext = m_rdata;
          stateNext  = ARB_RESP;
        end
      end
      ARB_GNT_D: begin
        if (m_ack) begin
          mReqNext  = 1'b0;
          mWeNext   = WE_READ;
          dAckNext  = 1'b1;
          stateNext = ARB_RESP;
          if (m_we == WE_READ) begin
            dRdataNext = m_rdata;
          end
        end
      end
      ARB_RESP: begin
        stateNext = ARB_IDLE;
      end
      default: begin
        stateNext = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Self-checking bench for mem_bus_arbiter: a table of single accesses,
// hand-written corner sequences (starvation, reset mid-access, spurious
// ack) and a randomized run against a transaction-level policy model.
// The bench plays the memory slave; outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk, rst;
  logic        i_req, i_ack, d_req, d_ack, m_req, m_ack, stall;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  d_we, m_we;

  int passes = 0;
  int checks = 0;

  // Transaction-level model of the arbitration policy.
  int          starve;
  bit          lastD;
  logic [31:0] expIRdata, expDRdata;

  typedef struct {
    bit          reqI;
    bit          reqD;
    logic [3:0]  we;
    logic [31:0] iAddr;
    logic [31:0] dAddr;
    logic [31:0] wdata;
    int          k;
    logic [31:0] rdata;
    logic [31:0] expFirstAddr;
  } vec_t;

  vec_t vecs[5];

  mem_bus_arbiter #(
    .AW         (32),
    .DW         (32),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Winner of the next grant, from the policy rules alone.
  function automatic bit predictD();
    if (d_req && !i_req) return 1'b1;
    if (i_req && !d_req) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return !lastD;
`else
    return (starve != STARVE_MAX);
`endif
  endfunction

  task automatic noteGrant(input bit wonD);
    if (wonD) starve = i_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
    else      starve = 0;
    lastD = wonD;
  endtask

  task automatic applyReset();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    step();
    step();
    checkOutput("reset m_req", m_req, 1'b0);
    checkOutput("reset m_we", m_we, 4'b0000);
    checkOutput("reset m_addr", m_addr, 32'h0);
    checkOutput("reset m_wdata", m_wdata, 32'h0);
    checkOutput("reset i_ack", i_ack, 1'b0);
    checkOutput("reset d_ack", d_ack, 1'b0);
    checkOutput("reset i_rdata", i_rdata, 32'h0);
    checkOutput("reset d_rdata", d_rdata, 32'h0);
    checkOutput("reset stall", stall, 1'b0);
    starve = 0; lastD = 1'b0; expIRdata = '0; expDRdata = '0;
    rst = 1'b1;
    step();
  endtask

  // Called at a falling edge in IDLE with the new request(s) already driven.
  // Serves one grant as the memory slave with k wait cycles and drops the
  // winner's request in its ack cycle.
  task automatic serveOne(input int k, input logic [31:0] rdata,
                          output logic [31:0] gotAddr);
    bit          expD;
    logic [3:0]  expWe;
    logic [31:0] expAddr;
    int          waited;
    expD    = predictD();
    expWe   = expD ? d_we : 4'b0000;
    expAddr = expD ? d_addr : i_addr;
    step();
    checkOutput("grant latency m_req", m_req, 1'b1);
    waited = 0;
    while (!m_req && waited < 10) begin
      step();
      waited++;
    end
    noteGrant(expD);
    gotAddr = m_addr;
    if (expD) checkOutput("grant m_wdata", m_wdata, d_wdata);
    for (int j = 0; j <= k; j++) begin
      checkOutput("hold m_req", m_req, 1'b1);
      checkOutput("hold m_addr", m_addr, expAddr);
      checkOutput("hold m_we", m_we, expWe);
      checkOutput("no early ack", {i_ack, d_ack}, 2'b00);
      checkOutput("stall while waiting", stall, 1'b1);
      if (j < k) step();
    end
    m_ack = 1'b1;
    m_rdata = rdata;
    step();
    m_ack = 1'b0;
    m_rdata = $urandom;
    if (expD) begin
      if (d_we == 4'b0000) expDRdata = rdata;
    end else begin
      expIRdata = rdata;
    end
    checkOutput("ack i_ack", i_ack, !expD);
    checkOutput("ack d_ack", d_ack, expD);
    checkOutput("ack i_rdata", i_rdata, expIRdata);
    checkOutput("ack d_rdata", d_rdata, expDRdata);
    checkOutput("ack m_req low", m_req, 1'b0);
    checkOutput("ack m_we low", m_we, 4'b0000);
    checkOutput("ack stall", stall, expD ? i_req : d_req);
    if (expD) d_req = 1'b0;
    else      i_req = 1'b0;
    step();
    checkOutput("ack pulse one cycle", {i_ack, d_ack}, 2'b00);
  endtask

  task automatic raiseI(input logic [31:0] addr);
    i_req = 1'b1; i_addr = addr;
  endtask

  task automatic raiseD(input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] got, dummy;
    if (v.reqI) raiseI(v.iAddr);
    if (v.reqD) raiseD(v.we, v.dAddr, v.wdata);
    serveOne(v.k, v.rdata, got);
    checkOutput("table first grant addr", got, v.expFirstAddr);
    if (i_req || d_req) serveOne(0, ~v.rdata, dummy);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] expOrder[10];
    i_addr = '0; d_we = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    vecs[0] = '{1'b1, 1'b0, 4'b0000, 32'h0040_0000, 32'h0, 32'h0, 0,
                32'h2408_000A, 32'h0040_0000};
    vecs[1] = '{1'b0, 1'b1, 4'b0011, 32'h0, 32'h1001_0004, 32'h0000_BEEF, 3,
                32'hDEAD_0001, 32'h1001_0004};
    vecs[2] = '{1'b0, 1'b1, 4'b0000, 32'h0, 32'h1001_0008, 32'h0, 1,
                32'h1234_5678, 32'h1001_0008};
    vecs[3] = '{1'b1, 1'b1, 4'b0000, 32'h0040_0004, 32'h1001_000C, 32'h0, 0,
                32'hCAFE_F00D, 32'h1001_000C};
    vecs[4] = '{1'b1, 1'b0, 4'b0000, 32'h0040_0008, 32'h0, 32'h0, 2,
                32'h8C09_0000, 32'h0040_0008};

    applyReset();
    for (int n = 0; n < 5; n++) applyStimulus(vecs[n]);

    // Both requesters held continuously.
    applyReset();
`ifdef ARB_ROUND_ROBIN_EN
    for (int n = 0; n < 10; n++) expOrder[n] = (n % 2 == 0) ? 32'h1001_0100 : 32'h0040_0100;
`else
    for (int n = 0; n < 10; n++) expOrder[n] = (n % 5 == 4) ? 32'h0040_0100 : 32'h1001_0100;
`endif
    raiseI(32'h0040_0100);
    raiseD(4'b0000, 32'h1001_0100, 32'h0);
    for (int n = 0; n < 10; n++) begin
      serveOne(0, 32'h5500_0000 + n, got);
      checkOutput("tie grant order", got, expOrder[n]);
      if (!i_req) raiseI(32'h0040_0100);
      if (!d_req) raiseD(4'b0000, 32'h1001_0100, 32'h0);
    end
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Reset while a data access is in flight.
    applyReset();
    raiseD(4'b0000, 32'h1001_0200, 32'h0);
    step();
    checkOutput("pre-reset m_req", m_req, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("async reset m_req", m_req, 1'b0);
    checkOutput("async reset m_addr", m_addr, 32'h0);
    step();
    checkOutput("reset no d_ack", d_ack, 1'b0);
    starve = 0; lastD = 1'b0; expIRdata = '0; expDRdata = '0;
    rst = 1'b1;
    serveOne(1, 32'h0BAD_CAFE, got);
    checkOutput("regrant after reset", got, 32'h1001_0200);

    // Spurious ack with nobody requesting.
    m_ack = 1'b1;
    m_rdata = 32'hFFFF_FFFF;
    for (int n = 0; n < 3; n++) begin
      step();
      checkOutput("spurious m_req", m_req, 1'b0);
      checkOutput("spurious acks", {i_ack, d_ack}, 2'b00);
      checkOutput("spurious stall", stall, 1'b0);
      checkOutput("spurious d_rdata", d_rdata, expDRdata);
    end
    m_ack = 1'b0;
    raiseI(32'h0040_0300);
    serveOne(0, 32'h1111_2222, got);

    // Randomized traffic against the policy model.
    applyReset();
    for (int n = 0; n < 60; n++) begin
      if (!i_req && $urandom_range(0, 1) == 1)
        raiseI(32'h0040_0000 | ($urandom & 32'h0000_FFFC));
      if (!d_req && $urandom_range(0, 1) == 1)
        raiseD(($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15)),
               32'h1001_0000 | ($urandom & 32'h0000_FFFC), $urandom);
      if (!i_req && !d_req) raiseI(32'h0040_0000 | ($urandom & 32'h0000_FFFC));
      serveOne($urandom_range(0, 3), $urandom, got);
    end
    while (i_req || d_req) serveOne(0, $urandom, got);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
